// File: rtl/mem_line_arbiter.sv
// Shares one line-wide memory port between icache refills and dcache write-back + refill.
// One memory transaction is outstanding at a time; simultaneous misses are granted round-robin.
module mem_line_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 512,
  parameter int OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wb_valid,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_line,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // r_last_d / r_gnt_d: 0 = icache, 1 = dcache
  logic              r_last_d;
  logic              r_gnt_d;
  logic [TAG_W-1:0]  r_addr;
  logic [TAG_W-1:0]  r_wb_addr;
  logic [LINE_W-1:0] r_wb_data;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic              w_mem_req_next;
  logic              w_mem_we_next;
  logic [ADDR_W-1:0] w_mem_addr_next;
  logic [LINE_W-1:0] w_mem_wdata_next;

  logic              r_i_ready;
  logic              r_d_ready;
  logic [LINE_W-1:0] r_i_line;
  logic [LINE_W-1:0] r_d_line;

  logic              w_any_req;
  logic              w_pick_d;
  logic              w_grant;
  logic              w_rd_done;
  logic [1:0]        w_req;
  logic [1:0]        w_capture;
  logic [1:0]        w_ready_next;
  logic              w_unused_offsets;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {OFFSET_W{1'b0}}};
  endfunction

  assign w_req     = {d_req, i_req};
  assign w_any_req = i_req | d_req;
  // On a tie the requester that was not served last wins.
  assign w_pick_d  = d_req & (~i_req | ~r_last_d);
  assign w_grant   = (r_state == IDLE) & w_any_req;
  assign w_rd_done = (r_state == RD) & mem_ack;

  // Line offsets never reach memory; addresses are always line-aligned.
  assign w_unused_offsets = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0],
                              d_wb_addr[OFFSET_W-1:0]};

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = 1'b0;
    w_mem_we_next    = 1'b0;
    w_mem_addr_next  = '0;
    w_mem_wdata_next = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_mem_req_next = 1'b1;
          if (w_pick_d && d_wb_valid) begin
            w_state_next     = WB;
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = line_addr(d_wb_addr[ADDR_W-1:OFFSET_W]);
            w_mem_wdata_next = d_wb_data;
          end else begin
            w_state_next    = RD;
            w_mem_addr_next = w_pick_d ? line_addr(d_addr[ADDR_W-1:OFFSET_W])
                                       : line_addr(i_addr[ADDR_W-1:OFFSET_W]);
          end
        end
      end
      WB: begin
        w_mem_req_next = 1'b1;
        if (mem_ack) begin
          // Refill read goes out immediately, mem_req never drops in between.
          w_state_next    = RD;
          w_mem_addr_next = line_addr(r_addr);
        end else begin
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = line_addr(r_wb_addr);
          w_mem_wdata_next = r_wb_data;
        end
      end
      RD: begin
        if (mem_ack) begin
          w_state_next = RESP;
        end else begin
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = line_addr(r_addr);
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // A requester that dropped its request mid-transaction still gets its line
  // register refreshed, but sees no ready pulse.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign w_capture[gi]    = w_rd_done & (r_gnt_d == 1'(gi));
    assign w_ready_next[gi] = w_capture[gi] & w_req[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_gnt_d     <= 1'b0;
      r_addr      <= '0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      if (w_grant) begin
        r_gnt_d   <= w_pick_d;
        r_addr    <= w_pick_d ? d_addr[ADDR_W-1:OFFSET_W] : i_addr[ADDR_W-1:OFFSET_W];
        r_wb_addr <= d_wb_addr[ADDR_W-1:OFFSET_W];
        r_wb_data <= d_wb_data;
      end
      if (r_state == RESP) begin
        r_last_d <= r_gnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_line  <= '0;
      r_d_line  <= '0;
    end else begin
      r_i_ready <= w_ready_next[0];
      r_d_ready <= w_ready_next[1];
      if (w_capture[0]) begin
        r_i_line <= mem_rdata;
      end
      if (w_capture[1]) begin
        r_d_line <= mem_rdata;
      end
    end
  end

  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign i_line    = r_i_line;
  assign d_line    = r_d_line;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter: cycle table for single misses, hand sequences for
// round-robin, dropped requests and reset during write-back.
module tb_mem_line_arbiter;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 512;
  localparam int OFFSET_W = 6;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [LINE_W-1:0] i_line;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wb_valid;
  logic [ADDR_W-1:0] d_wb_addr;
  logic [LINE_W-1:0] d_wb_data;
  logic              d_ready;
  logic [LINE_W-1:0] d_line;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_line_arbiter #(
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .OFFSET_W(OFFSET_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_line    (i_line),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wb_valid(d_wb_valid),
    .d_wb_addr (d_wb_addr),
    .d_wb_data (d_wb_data),
    .d_ready   (d_ready),
    .d_line    (d_line),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, recognisable line patterns; index 0 means an all-zero line.
  function automatic logic [LINE_W-1:0] pat(input int k);
    logic [31:0] w;
    if (k == 0) return '0;
    w = 32'hC0DE_0000 + 32'(k);
    return {16{w}};
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_addr(input string name, input logic [ADDR_W-1:0] act,
                          input logic [ADDR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (mem_req === 1'b1) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: mem_req got 0 expected 1 within 20 cycles", tag);
    end
  endtask

  // Serves one read: checks the request, acks after lat cycles, checks the response.
  task automatic run_read(input string tag, input logic [ADDR_W-1:0] exp_addr, input int lat,
                          input int rk, input bit to_d, input bit exp_rdy);
    bit ok;
    wait_req(tag, ok);
    if (!ok) return;
    chk_bit ({tag, " we"}, mem_we, 1'b0);
    chk_addr({tag, " addr"}, mem_addr, exp_addr);
    chk_line({tag, " wdata"}, mem_wdata, '0);
    for (int c = 1; c < lat; c++) begin
      tick();
      chk_bit ({tag, " hold req"}, mem_req, 1'b1);
      chk_addr({tag, " hold addr"}, mem_addr, exp_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = pat(rk);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk_bit({tag, " req drop"}, mem_req, 1'b0);
    chk_bit({tag, " i_ready"}, i_ready, to_d ? 1'b0 : exp_rdy);
    chk_bit({tag, " d_ready"}, d_ready, to_d ? exp_rdy : 1'b0);
    if (to_d) chk_line({tag, " d_line"}, d_line, pat(rk));
    else      chk_line({tag, " i_line"}, i_line, pat(rk));
    tick();
    chk_bit({tag, " i_ready end"}, i_ready, 1'b0);
    chk_bit({tag, " d_ready end"}, d_ready, 1'b0);
    chk_bit({tag, " idle gap"}, mem_req, 1'b0);
    $display("txn %s: read %h for %s, line sel %0d", tag, exp_addr, to_d ? "dcache" : "icache", rk);
  endtask

  task automatic run_write(input string tag, input logic [ADDR_W-1:0] exp_addr, input int wk);
    bit ok;
    wait_req(tag, ok);
    if (!ok) return;
    chk_bit ({tag, " we"}, mem_we, 1'b1);
    chk_addr({tag, " addr"}, mem_addr, exp_addr);
    chk_line({tag, " wdata"}, mem_wdata, pat(wk));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk_bit ({tag, " req stays"}, mem_req, 1'b1);
    chk_bit ({tag, " we after"}, mem_we, 1'b0);
    chk_line({tag, " wdata after"}, mem_wdata, '0);
    $display("txn %s: write %h, data sel %0d", tag, exp_addr, wk);
  endtask

  typedef struct {
    bit          rst_n;
    bit          i_req;
    logic [31:0] i_addr;
    bit          d_req;
    logic [31:0] d_addr;
    bit          wbv;
    logic [31:0] wb_addr;
    int          wsel;
    bit          ack;
    int          rsel;
    bit          e_req;
    bit          e_we;
    logic [31:0] e_addr;
    int          e_wsel;
    bit          e_irdy;
    bit          e_drdy;
    int          e_iline;
    int          e_dline;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs (rst,ireq,iaddr,dreq,daddr,wbv,wbaddr,wsel,ack,rsel) | expected outputs after the edge
    vt[0]  = '{L,L,32'h0,L,32'h0,L,32'h0,0,L,0,                       L,L,32'h0,0,L,L,0,0};
    vt[1]  = '{H,H,32'h0000_1234,L,32'h0,L,32'h0,0,L,0,               H,L,32'h0000_1200,0,L,L,0,0};
    vt[2]  = '{H,H,32'h0000_1234,L,32'h0,L,32'h0,0,L,0,               H,L,32'h0000_1200,0,L,L,0,0};
    vt[3]  = '{H,H,32'h0000_1234,L,32'h0,L,32'h0,0,L,0,               H,L,32'h0000_1200,0,L,L,0,0};
    vt[4]  = '{H,H,32'h0000_1234,L,32'h0,L,32'h0,0,H,1,               L,L,32'h0,0,H,L,1,0};
    vt[5]  = '{H,L,32'h0,L,32'h0,L,32'h0,0,L,0,                       L,L,32'h0,0,L,L,1,0};
    vt[6]  = '{H,L,32'h0,L,32'h0,L,32'h0,0,H,5,                       L,L,32'h0,0,L,L,1,0};
    vt[7]  = '{H,L,32'h0,L,32'h0,L,32'h0,0,L,0,                       L,L,32'h0,0,L,L,1,0};
    vt[8]  = '{H,L,32'h0,H,32'h0000_2048,H,32'h8000_0FC0,2,L,0,       H,H,32'h8000_0FC0,2,L,L,1,0};
    vt[9]  = '{H,L,32'h0,H,32'h3333_3300,L,32'h1111_1100,3,L,0,       H,H,32'h8000_0FC0,2,L,L,1,0};
    vt[10] = '{H,L,32'h0,H,32'h3333_3300,L,32'h1111_1100,3,H,0,       H,L,32'h0000_2040,0,L,L,1,0};
    vt[11] = '{H,L,32'h0,H,32'h3333_3300,L,32'h1111_1100,3,L,0,       H,L,32'h0000_2040,0,L,L,1,0};
    vt[12] = '{H,L,32'h0,H,32'h3333_3300,L,32'h1111_1100,3,H,4,       L,L,32'h0,0,L,H,1,4};
    vt[13] = '{H,L,32'h0,L,32'h0,L,32'h0,0,L,0,                       L,L,32'h0,0,L,L,1,4};

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wb_valid = 1'b0; d_wb_addr = '0; d_wb_data = '0; mem_ack = 1'b0; mem_rdata = '0;

    for (int k = 0; k < 14; k++) begin
      rst_n      = vt[k].rst_n;
      i_req      = vt[k].i_req;
      i_addr     = vt[k].i_addr;
      d_req      = vt[k].d_req;
      d_addr     = vt[k].d_addr;
      d_wb_valid = vt[k].wbv;
      d_wb_addr  = vt[k].wb_addr;
      d_wb_data  = pat(vt[k].wsel);
      mem_ack    = vt[k].ack;
      mem_rdata  = pat(vt[k].rsel);
      tick();
      chk_bit ($sformatf("v%0d mem_req", k), mem_req, vt[k].e_req);
      chk_bit ($sformatf("v%0d mem_we", k), mem_we, vt[k].e_we);
      chk_addr($sformatf("v%0d mem_addr", k), mem_addr, vt[k].e_addr);
      chk_line($sformatf("v%0d mem_wdata", k), mem_wdata, pat(vt[k].e_wsel));
      chk_bit ($sformatf("v%0d i_ready", k), i_ready, vt[k].e_irdy);
      chk_bit ($sformatf("v%0d d_ready", k), d_ready, vt[k].e_drdy);
      chk_line($sformatf("v%0d i_line", k), i_line, pat(vt[k].e_iline));
      chk_line($sformatf("v%0d d_line", k), d_line, pat(vt[k].e_dline));
      $display("vec %0d: req=%b we=%b addr=%h irdy=%b drdy=%b", k, mem_req, mem_we, mem_addr,
               i_ready, d_ready);
    end
    mem_ack = 1'b0; mem_rdata = '0; d_wb_data = '0; d_wb_valid = 1'b0; d_wb_addr = '0;

    // Both caches miss continuously from reset: d, i, d, i.
    rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h4000_0040; d_req = 1'b1; d_addr = 32'h5000_0080;
    tick();
    chk_bit("rr reset mem_req", mem_req, 1'b0);
    rst_n = 1'b1;
    run_read("rr0", 32'h5000_0080, 2, 10, 1'b1, 1'b1);
    run_read("rr1", 32'h4000_0040, 2, 11, 1'b0, 1'b1);
    run_read("rr2", 32'h5000_0080, 2, 12, 1'b1, 1'b1);
    run_read("rr3", 32'h4000_0040, 2, 13, 1'b0, 1'b1);
    i_req = 1'b0; d_req = 1'b0;

    // icache drops its request during RD: no pulse, but last-grant moves to icache.
    d_req = 1'b1; d_addr = 32'h6000_0100;
    run_read("dsolo", 32'h6000_0100, 1, 20, 1'b1, 1'b1);
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h7000_01C0;
    begin
      bit ok;
      wait_req("drop", ok);
      if (ok) begin
        chk_addr("drop addr", mem_addr, 32'h7000_01C0);
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h6000_0140;
        tick();
        chk_addr("drop hold addr", mem_addr, 32'h7000_01C0);
        mem_ack = 1'b1; mem_rdata = pat(21);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk_bit ("drop i_ready", i_ready, 1'b0);
        chk_bit ("drop d_ready", d_ready, 1'b0);
        chk_bit ("drop req", mem_req, 1'b0);
        chk_line("drop i_line", i_line, pat(21));
        $display("txn drop: read 700001c0 completed without ready");
        i_req = 1'b1;
      end
    end
    run_read("after_drop", 32'h6000_0140, 1, 22, 1'b1, 1'b1);
    d_req = 1'b0;
    run_read("i_after", 32'h7000_01C0, 1, 23, 1'b0, 1'b1);
    i_req = 1'b0;

    // Reset in the middle of a write-back, then a clean restart.
    d_req = 1'b1; d_addr = 32'h0000_3000; d_wb_valid = 1'b1; d_wb_addr = 32'h9000_0040;
    d_wb_data = pat(30);
    begin
      bit ok;
      wait_req("rstwb", ok);
      if (ok) begin
        chk_bit ("rstwb we", mem_we, 1'b1);
        chk_addr("rstwb addr", mem_addr, 32'h9000_0040);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_bit ("rst mem_req", mem_req, 1'b0);
        chk_bit ("rst mem_we", mem_we, 1'b0);
        chk_addr("rst mem_addr", mem_addr, '0);
        chk_line("rst mem_wdata", mem_wdata, '0);
        chk_bit ("rst i_ready", i_ready, 1'b0);
        chk_bit ("rst d_ready", d_ready, 1'b0);
        chk_line("rst i_line", i_line, '0);
        chk_line("rst d_line", d_line, '0);
        $display("txn rstwb: write abandoned by reset");
      end
    end
    run_write("restart_wb", 32'h9000_0040, 30);
    run_read("restart_rd", 32'h0000_3000, 1, 31, 1'b1, 1'b1);
    d_req = 1'b0; d_wb_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
